// File: rtl/compare_counter.sv
// General-purpose timer core: up/down/centre-aligned counting, one-shot, CHANNELS compare units.
// Optional prescaler built only when COMPARE_COUNTER_PRESCALER_EN is defined.
module compare_counter #(
  parameter int BITS     = 8,
  parameter int CHANNELS = 2,
  parameter int PRE_BITS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ena,
  input  logic [1:0]               i_mode,
  input  logic                     i_oneshot,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [BITS-1:0]          i_top,
  input  logic [BITS-1:0]          i_value,
  input  logic                     i_load,
  input  logic [PRE_BITS-1:0]      i_prescale,
  input  logic [CHANNELS*BITS-1:0] i_cmp,
  output logic [BITS-1:0]          o_out,
  output logic                     o_ovf,
  output logic                     o_running,
  output logic                     o_dir,
  output logic [CHANNELS-1:0]      o_match,
  output logic [CHANNELS-1:0]      o_cmp_out
);
  localparam logic [BITS-1:0] ONE = BITS'(1);

  logic [BITS-1:0]     r_cnt;
  logic                r_dir, r_running, r_ovf;
  logic [CHANNELS-1:0] r_cmp_out;
  logic [CHANNELS-1:0] w_lt;
  logic                w_pre_term, w_tick;
  logic [BITS-1:0]     w_nxt_cnt;
  logic                w_nxt_dir, w_wrap;

`ifdef COMPARE_COUNTER_PRESCALER_EN
  logic [PRE_BITS-1:0] r_pre;
  // >= rather than == so a prescale lowered mid-count still terminates
  assign w_pre_term = (r_pre >= i_prescale);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load || (!i_stop && i_start))
      r_pre <= '0;
    else if (!i_stop && r_running && i_ena)
      r_pre <= w_pre_term ? '0 : r_pre + PRE_BITS'(1);
  end
`else
  logic w_unused_prescale;
  assign w_unused_prescale = ^i_prescale;
  assign w_pre_term        = 1'b1;
`endif

  assign w_tick = r_running & i_ena & w_pre_term;

  always_comb begin
    w_nxt_cnt = r_cnt;
    w_nxt_dir = r_dir;
    w_wrap    = 1'b0;
    case (i_mode)
      2'b01: begin
        w_nxt_dir = 1'b0;
        if (r_cnt == '0) begin
          w_nxt_cnt = i_top;
          w_wrap    = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt - ONE;
        end
      end
      2'b10: begin
        // top = 0 would otherwise bounce to top-1 = all ones
        if (i_top == '0) begin
          w_nxt_cnt = '0;
          w_wrap    = 1'b1;
        end else if (r_dir && r_cnt >= i_top) begin
          w_nxt_dir = 1'b0;
          w_nxt_cnt = i_top - ONE;
        end else if (!r_dir && r_cnt == '0) begin
          w_nxt_dir = 1'b1;
          w_nxt_cnt = ONE;
          w_wrap    = 1'b1;
        end else begin
          w_nxt_cnt = r_dir ? r_cnt + ONE : r_cnt - ONE;
        end
      end
      default: begin
        w_nxt_dir = 1'b1;
        if (r_cnt >= i_top) begin
          w_nxt_cnt = '0;
          w_wrap    = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + ONE;
        end
      end
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [BITS-1:0] w_cmpv;
    assign w_cmpv     = i_cmp[g*BITS +: BITS];
    assign o_match[g] = r_running & (r_cnt == w_cmpv);
    assign w_lt[g]    = r_running & (r_cnt < w_cmpv);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_dir     <= 1'b1;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
      r_cmp_out <= '0;
    end else begin
      r_ovf     <= 1'b0;
      r_cmp_out <= w_lt;
      if (i_load) begin
        r_cnt <= i_value;
      end else if (i_stop) begin
        r_running <= 1'b0;
      end else if (i_start) begin
        r_running <= 1'b1;
        r_cnt     <= (i_mode == 2'b01) ? i_top : '0;
        r_dir     <= (i_mode != 2'b01);
      end else if (w_tick) begin
        r_cnt <= w_nxt_cnt;
        r_dir <= w_nxt_dir;
        if (w_wrap) begin
          r_ovf <= 1'b1;
          if (i_oneshot) r_running <= 1'b0;
        end
      end
    end
  end

  assign o_out     = r_cnt;
  assign o_ovf     = r_ovf;
  assign o_running = r_running;
  assign o_dir     = r_dir;
  assign o_cmp_out = r_cmp_out;
endmodule

// File: tb/tb_compare_counter.sv
// Bench for compare_counter: directed test-plan sequences, then randomized traffic
// checked every cycle against a behavioural model.
module tb_compare_counter;
  localparam int BITS = 8, CH = 2, PB = 4;

  logic              clk = 1'b0;
  logic              rst, ena, oneshot, start, stop, load;
  logic [1:0]        mode;
  logic [BITS-1:0]   top, value;
  logic [PB-1:0]     prescale;
  logic [CH*BITS-1:0] cmp;
  logic [BITS-1:0]   out;
  logic              ovf, running, dir;
  logic [CH-1:0]     match, cmp_out;

  compare_counter #(.BITS(BITS), .CHANNELS(CH), .PRE_BITS(PB)) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_mode(mode), .i_oneshot(oneshot),
    .i_start(start), .i_stop(stop), .i_top(top), .i_value(value), .i_load(load),
    .i_prescale(prescale), .i_cmp(cmp), .o_out(out), .o_ovf(ovf),
    .o_running(running), .o_dir(dir), .o_match(match), .o_cmp_out(cmp_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  // model state
  int m_cnt = 0, m_dir = 1, m_run = 0, m_ovf = 0, m_pre = 0;
  int m_cmpo[CH];
  int n_cnt, n_dir, n_run, n_ovf, n_pre;
  int n_cmpo[CH];

  int exp_up_out[6]  = '{0, 1, 2, 3, 0, 1};
  int exp_up_ovf[6]  = '{0, 0, 0, 0, 1, 0};
  int exp_up_cmpo[6] = '{0, 1, 1, 0, 0, 1};
  int exp_dn_out[7]  = '{5, 4, 3, 2, 1, 0, 5};
  int exp_ud_out[8]  = '{0, 1, 2, 3, 2, 1, 0, 1};
  int exp_ud_dir[8]  = '{1, 1, 1, 1, 0, 0, 0, 1};
  int exp_ud_ovf[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};

  function automatic int cmpv(int i);
    return int'(cmp[i*BITS +: BITS]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Next state from the behavioural rules, using pre-edge state and current inputs.
  task automatic model_next();
    int wrap;
    bit tick;
    for (int i = 0; i < CH; i++) n_cmpo[i] = (m_run != 0 && m_cnt < cmpv(i)) ? 1 : 0;
    n_cnt = m_cnt; n_dir = m_dir; n_run = m_run; n_ovf = 0; n_pre = m_pre;
    if (rst) begin
      n_cnt = 0; n_dir = 1; n_run = 0; n_pre = 0;
      for (int i = 0; i < CH; i++) n_cmpo[i] = 0;
    end else if (load) begin
      n_cnt = int'(value); n_pre = 0;
    end else if (stop) begin
      n_run = 0;
    end else if (start) begin
      n_run = 1; n_pre = 0;
      n_cnt = (mode == 2'b01) ? int'(top) : 0;
      n_dir = (mode == 2'b01) ? 0 : 1;
    end else if (m_run != 0 && ena) begin
`ifdef COMPARE_COUNTER_PRESCALER_EN
      tick  = (m_pre >= int'(prescale));
      n_pre = tick ? 0 : m_pre + 1;
`else
      tick = 1'b1;
`endif
      if (tick) begin
        wrap = 0;
        case (mode)
          2'b01: begin
            n_dir = 0;
            if (m_cnt == 0) begin n_cnt = int'(top); wrap = 1; end
            else n_cnt = m_cnt - 1;
          end
          2'b10: begin
            if (top == 0) begin n_cnt = 0; wrap = 1; end
            else if (m_dir == 1 && m_cnt >= int'(top)) begin n_dir = 0; n_cnt = int'(top) - 1; end
            else if (m_dir == 0 && m_cnt == 0) begin n_dir = 1; n_cnt = 1; wrap = 1; end
            else n_cnt = (m_dir == 1) ? m_cnt + 1 : m_cnt - 1;
          end
          default: begin
            n_dir = 1;
            if (m_cnt >= int'(top)) begin n_cnt = 0; wrap = 1; end
            else n_cnt = m_cnt + 1;
          end
        endcase
        if (wrap != 0) begin
          n_ovf = 1;
          if (oneshot) n_run = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    model_next();
    @(posedge clk);
    #1;
    m_cnt = n_cnt; m_dir = n_dir; m_run = n_run; m_ovf = n_ovf; m_pre = n_pre;
    for (int i = 0; i < CH; i++) m_cmpo[i] = n_cmpo[i];
    chk("m_out", 32'(out), 32'(m_cnt));
    chk("m_ovf", 32'(ovf), 32'(m_ovf));
    chk("m_running", 32'(running), 32'(m_run));
    chk("m_dir", 32'(dir), 32'(m_dir));
    for (int i = 0; i < CH; i++) begin
      chk("m_match", 32'(match[i]), (m_run != 0 && m_cnt == cmpv(i)) ? 32'd1 : 32'd0);
      chk("m_cmp_out", 32'(cmp_out[i]), 32'(m_cmpo[i]));
    end
  endtask

  initial begin
    rst = 1; ena = 0; oneshot = 0; start = 0; stop = 0; load = 0;
    mode = 2'b00; top = 0; value = 0; prescale = 0; cmp = '0;
    for (int i = 0; i < CH; i++) m_cmpo[i] = 0;
    cyc();
    chk("rst_out", 32'(out), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_cmp_out", 32'(cmp_out), 0);
    rst = 0; ena = 1;

    // up, continuous, top=3, cmp0=2
    mode = 2'b00; top = 3; cmp = {8'd0, 8'd2};
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      chk("up_out", 32'(out), 32'(exp_up_out[k]));
      chk("up_ovf", 32'(ovf), 32'(exp_up_ovf[k]));
      chk("up_cmp_out", 32'(cmp_out[0]), 32'(exp_up_cmpo[k]));
    end

    // down, oneshot, top=5
    mode = 2'b01; top = 5; oneshot = 1;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cyc();
      chk("dn_out", 32'(out), 32'(exp_dn_out[k]));
      chk("dn_ovf", 32'(ovf), (k == 6) ? 32'd1 : 32'd0);
      chk("dn_running", 32'(running), (k == 6) ? 32'd0 : 32'd1);
    end
    cyc();
    chk("dn_hold", 32'(out), 5);
    chk("dn_hold_run", 32'(running), 0);

    // up/down, top=3, then top=0
    mode = 2'b10; top = 3; oneshot = 0;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      chk("ud_out", 32'(out), 32'(exp_ud_out[k]));
      chk("ud_dir", 32'(dir), 32'(exp_ud_dir[k]));
      chk("ud_ovf", 32'(ovf), 32'(exp_ud_ovf[k]));
    end
    top = 0;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ud0_out", 32'(out), 0);
      chk("ud0_ovf", 32'(ovf), 1);
    end

    // prescaler, up, top=1
    mode = 2'b00; top = 1; prescale = 2;
    start = 1; cyc(); start = 0;
    cyc();
`ifdef COMPARE_COUNTER_PRESCALER_EN
    chk("pre_out", 32'(out), 0);
`else
    chk("pre_out", 32'(out), 1);
`endif
    for (int k = 0; k < 6; k++) cyc();
    prescale = 0;

    // priority: stop > start, load > start/stop
    stop = 1; start = 1; cyc();
    chk("stop_start_run", 32'(running), 0);
    stop = 0; load = 1; value = 7; cyc(); load = 0; start = 0;
    chk("load_start_out", 32'(out), 7);
    chk("load_start_run", 32'(running), 0);
    start = 1; cyc(); start = 0;
    load = 1; stop = 1; value = 9; cyc(); load = 0; stop = 0;
    chk("load_stop_out", 32'(out), 9);
    chk("load_stop_run", 32'(running), 1);

    // reset mid-count
    mode = 2'b00; top = 3; cmp = {8'd5, 8'd6};
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    chk("mid_out", 32'(out), 2);
    rst = 1; cyc(); rst = 0;
    chk("mid_rst_out", 32'(out), 0);
    chk("mid_rst_run", 32'(running), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_cmp", 32'(cmp_out), 0);
    chk("mid_rst_dir", 32'(dir), 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        mode = 2'($urandom_range(0, 3));
        top = 8'($urandom_range(0, 9));
        prescale = 4'($urandom_range(0, 3));
        oneshot = 1'($urandom_range(0, 1));
        cmp = {8'($urandom_range(0, 11)), 8'($urandom_range(0, 11))};
      end
      if (n % 37 == 0) mode = 2'($urandom_range(0, 3));
      ena   = ($urandom_range(0, 7) != 0);
      load  = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      value = 8'($urandom_range(0, 15));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
